// File: rtl/mem_wb_skid_stage.sv
// mem_wb_skid_stage: MEM->WB stage register with valid/ready, optional 2-entry skid, flush and forwarding
module mem_wb_skid_stage #(
  parameter int N    = 32,
  parameter int RW   = 5,
  parameter bit SKID = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_wr_en,
  input  logic          in_wd_sel,
  input  logic [RW-1:0] in_rw,
  input  logic [N-1:0]  in_alu_result,
  input  logic [N-1:0]  in_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_wr_en,
  output logic          out_wd_sel,
  output logic [RW-1:0] out_rw,
  output logic [N-1:0]  out_alu_result,
  output logic [N-1:0]  out_rd,
  output logic          fwd_en,
  output logic [RW-1:0] fwd_rw,
  output logic [N-1:0]  fwd_data,
  output logic [1:0]    occupancy
);
  typedef enum logic [1:0] {EMPTY = 2'd0, MAIN = 2'd1, FULL = 2'd2} state_t;
  typedef struct packed {
    logic          wr_en;
    logic          wd_sel;
    logic [RW-1:0] rw;
    logic [N-1:0]  alu;
    logic [N-1:0]  rd;
  } entry_t;
  state_t state_q, state_d;
  entry_t main_q, skid_q, in_e;
  logic acc, drn, ld_main, ld_skid, from_skid;
  assign in_e = '{wr_en: in_wr_en, wd_sel: in_wd_sel, rw: in_rw, alu: in_alu_result, rd: in_rd};
  assign acc  = in_valid & in_ready;
  assign drn  = out_valid & out_ready;
  always_comb begin
    state_d   = state_q;
    ld_main   = 1'b0;
    ld_skid   = 1'b0;
    from_skid = 1'b0;
    case (state_q)
      EMPTY: if (acc) begin
        state_d = MAIN;
        ld_main = 1'b1;
      end
      MAIN: if (acc && drn) ld_main = 1'b1;
      else if (acc) begin
        state_d = FULL;
        ld_skid = 1'b1;
      end else if (drn) state_d = EMPTY;
      FULL: if (drn) begin
        state_d   = MAIN;
        ld_main   = 1'b1;
        from_skid = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      ld_main = 1'b0;
      ld_skid = 1'b0;
    end
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state_q <= EMPTY;
    else state_q <= state_d;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (ld_main) main_q <= from_skid ? skid_q : in_e;
      if (ld_skid) skid_q <= in_e;
    end
  // with the skid buffer, in_ready is its own flop so out_ready never reaches it combinationally
  generate
    if (SKID) begin : g_skid
      logic rdy_q;
      always_ff @(posedge clock or negedge reset)
        if (!reset) rdy_q <= 1'b1;
        else rdy_q <= state_d != FULL;
      assign in_ready = rdy_q;
    end else begin : g_single
      assign in_ready = !out_valid | out_ready;
    end
  endgenerate
  assign out_valid      = state_q != EMPTY;
  assign out_wr_en      = main_q.wr_en & out_valid;
  assign out_wd_sel     = main_q.wd_sel;
  assign out_rw         = main_q.rw;
  assign out_alu_result = main_q.alu;
  assign out_rd         = main_q.rd;
  assign fwd_en         = out_wr_en & (main_q.rw != '0);
  assign fwd_rw         = main_q.rw;
  assign fwd_data       = main_q.wd_sel ? main_q.rd : main_q.alu;
  assign occupancy      = state_q;
endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// tb_mem_wb_skid_stage: directed checks of the skid stage (SKID=1) and the single-entry build (SKID=0)
module tb_mem_wb_skid_stage;
  logic clock = 1'b0, reset = 1'b0, flush = 1'b0;
  logic in_valid = 1'b0, in_wr_en = 1'b0, in_wd_sel = 1'b0, out_ready = 1'b0;
  logic [4:0] in_rw = '0;
  logic [31:0] in_alu = '0, in_rd = '0;
  logic in_ready, out_valid, out_wr_en, out_wd_sel, fwd_en;
  logic [4:0] out_rw, fwd_rw;
  logic [31:0] out_alu, out_rd, fwd_data;
  logic [1:0] occ;
  logic in_valid0 = 1'b0, out_ready0 = 1'b1;
  logic [31:0] in_alu0 = '0;
  logic in_ready0, out_valid0, out_wr_en0, out_wd_sel0, fwd_en0;
  logic [4:0] out_rw0, fwd_rw0;
  logic [31:0] out_alu0, out_rd0, fwd_data0;
  logic [1:0] occ0;
  int errors = 0, checks = 0;
  mem_wb_skid_stage #(.N(32), .RW(5), .SKID(1'b1)) u_dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_wr_en(in_wr_en), .in_wd_sel(in_wd_sel), .in_rw(in_rw), .in_alu_result(in_alu), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_wr_en(out_wr_en), .out_wd_sel(out_wd_sel),
    .out_rw(out_rw), .out_alu_result(out_alu), .out_rd(out_rd), .fwd_en(fwd_en), .fwd_rw(fwd_rw),
    .fwd_data(fwd_data), .occupancy(occ));
  mem_wb_skid_stage #(.N(32), .RW(5), .SKID(1'b0)) u_dut0 (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_wr_en(in_wr_en), .in_wd_sel(in_wd_sel), .in_rw(in_rw), .in_alu_result(in_alu0), .in_rd(in_rd),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_wr_en(out_wr_en0), .out_wd_sel(out_wd_sel0),
    .out_rw(out_rw0), .out_alu_result(out_alu0), .out_rd(out_rd0), .fwd_en(fwd_en0), .fwd_rw(fwd_rw0),
    .fwd_data(fwd_data0), .occupancy(occ0));
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic send(input logic v, input logic [31:0] alu);
    in_valid = v;
    in_alu = alu;
  endtask
  initial begin
    for (int i = 0; i < 3; i++) begin
      in_valid = $urandom; in_wr_en = $urandom; in_wd_sel = $urandom; in_rw = 5'($urandom);
      in_alu = $urandom; in_rd = $urandom; out_ready = $urandom; in_valid0 = $urandom; in_alu0 = $urandom;
      tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_occ", occ, 0);
      chk("rst_ready", in_ready, 1);
      chk("rst_wr_en", out_wr_en, 0);
      chk("rst_alu", out_alu, 0);
      chk("rst_fwd_data", fwd_data, 0);
      chk("rst_fwd_en", fwd_en, 0);
      chk("rst_occ0", occ0, 0);
    end
    in_valid = 0; in_valid0 = 0; out_ready0 = 1; in_wr_en = 1; in_wd_sel = 0; in_rw = 3; in_rd = 0;
    reset = 1;
    tick();
    chk("rel_valid", out_valid, 0);
    chk("rel_ready", in_ready, 1);
    chk("rel_rd", out_rd, 0);
    out_ready = 1;
    for (int i = 1; i <= 8; i++) begin
      send(1, i);
      tick();
      chk("str_valid", out_valid, 1);
      chk("str_alu", out_alu, i);
      chk("str_occ", occ, 1);
      chk("str_fwd_en", fwd_en, 1);
      chk("str_fwd_data", fwd_data, i);
      chk("str_rw", out_rw, 3);
    end
    send(0, 0);
    tick();
    chk("str_end_valid", out_valid, 0);
    chk("str_end_wr_en", out_wr_en, 0);
    out_ready = 0;
    send(1, 32'h11);
    tick();
    chk("bp_a_occ", occ, 1);
    chk("bp_a_ready", in_ready, 1);
    send(1, 32'h22);
    tick();
    chk("bp_b_occ", occ, 2);
    chk("bp_b_ready", in_ready, 0);
    chk("bp_b_alu", out_alu, 32'h11);
    send(1, 32'h44);
    tick();
    chk("bp_c_held_occ", occ, 2);
    chk("bp_c_held_alu", out_alu, 32'h11);
    out_ready = 1;
    tick();
    chk("bp_drain_b", out_alu, 32'h22);
    chk("bp_drain_occ", occ, 1);
    chk("bp_drain_ready", in_ready, 1);
    tick();
    chk("bp_drain_c", out_alu, 32'h44);
    chk("bp_c_occ", occ, 1);
    send(0, 0);
    tick();
    chk("bp_empty", occ, 0);
    out_ready = 0;
    send(1, 32'h55);
    tick();
    send(1, 32'h66);
    tick();
    chk("fl_full", occ, 2);
    send(1, 32'h33);
    flush = 1;
    tick();
    chk("fl_occ", occ, 0);
    chk("fl_valid", out_valid, 0);
    chk("fl_wr_en", out_wr_en, 0);
    chk("fl_fwd_en", fwd_en, 0);
    chk("fl_ready", in_ready, 1);
    flush = 0;
    send(0, 0);
    tick();
    chk("fl_not_stored", occ, 0);
    in_wd_sel = 1; in_rd = 32'hDEADBEEF; in_rw = 7;
    send(1, 32'h5);
    tick();
    chk("fwd_data", fwd_data, 32'hDEADBEEF);
    chk("fwd_rw", fwd_rw, 7);
    chk("fwd_en", fwd_en, 1);
    chk("fwd_alu", out_alu, 32'h5);
    out_ready = 1; in_rw = 0;
    tick();
    chk("fwd_rw0_en", fwd_en, 0);
    chk("fwd_rw0_wr_en", out_wr_en, 1);
    chk("fwd_rw0_occ", occ, 1);
    out_ready = 0;
    send(0, 0);
    tick();
    chk("mid_held", occ, 1);
    reset = 0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_rd", out_rd, 0);
    reset = 1;
    in_wd_sel = 0; in_rw = 9;
    tick();
    in_valid0 = 1; out_ready0 = 0; in_alu0 = 32'hA1;
    tick();
    chk("s0_occ", occ0, 1);
    chk("s0_alu", out_alu0, 32'hA1);
    chk("s0_ready_low", in_ready0, 0);
    in_alu0 = 32'hB2;
    tick();
    chk("s0_hold", out_alu0, 32'hA1);
    out_ready0 = 1;
    #1;
    chk("s0_ready_high", in_ready0, 1);
    tick();
    chk("s0_replace", out_alu0, 32'hB2);
    chk("s0_replace_occ", occ0, 1);
    in_valid0 = 0;
    tick();
    chk("s0_empty", occ0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
